// File: rtl/btn_reset_conditioner_if.sv
// Button-side bundle of the reset conditioner: raw push-button in and the
// conditioned reset, debounced level, press strobe and press counter out.
interface btn_reset_conditioner_if;
  logic       btn_raw;
  logic       core_reset;
  logic       btn_clean;
  logic       press_pulse;
  logic [7:0] press_count;

  modport master (
    output btn_raw,
    input  core_reset,
    input  btn_clean,
    input  press_pulse,
    input  press_count
  );

  modport slave (
    input  btn_raw,
    output core_reset,
    output btn_clean,
    output press_pulse,
    output press_count
  );
endinterface

// File: rtl/btn_reset_conditioner.sv
// Push-button to core reset conditioner: synchronizer, press/release debounce,
// power-on and per-press reset stretch, press strobe and wrapping press counter.
module btn_reset_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESET_CYCLES    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  btn_reset_conditioner_if.slave    bus
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    POR_HOLD = 3'd0,
    IDLE     = 3'd1,
    PRESS_DB = 3'd2,
    RST_HOLD = 3'd3,
    WAIT_REL = 3'd4,
    REL_DB   = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_btn_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_core_reset;
  logic                   r_btn_clean;
  logic                   r_press_pulse;
  logic [7:0]             r_press_count;

  assign w_btn_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.btn_raw};
    end
  end

  // Outputs are registered and only change on state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= POR_HOLD;
      r_cnt         <= '0;
      r_core_reset  <= 1'b1;
      r_btn_clean   <= 1'b0;
      r_press_pulse <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_press_pulse <= 1'b0;
      case (r_state)
        POR_HOLD: begin
          if (r_cnt == RST_LAST) begin
            r_cnt <= '0;
            // A button already held at power-up is treated as a release wait, not a press.
            if (w_btn_s) begin
              r_state     <= WAIT_REL;
              r_btn_clean <= 1'b1;
            end else begin
              r_state      <= IDLE;
              r_core_reset <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        IDLE: begin
          if (w_btn_s) begin
            r_state <= PRESS_DB;
            r_cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (!w_btn_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state       <= RST_HOLD;
            r_cnt         <= '0;
            r_core_reset  <= 1'b1;
            r_btn_clean   <= 1'b1;
            r_press_pulse <= 1'b1;
            r_press_count <= r_press_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RST_HOLD: begin
          if (r_cnt == RST_LAST) begin
            r_state <= WAIT_REL;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_REL: begin
          if (!w_btn_s) begin
            r_state <= REL_DB;
            r_cnt   <= '0;
          end
        end
        REL_DB: begin
          if (w_btn_s) begin
            r_state <= WAIT_REL;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_core_reset <= 1'b0;
            r_btn_clean  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state      <= POR_HOLD;
          r_cnt        <= '0;
          r_core_reset <= 1'b1;
          r_btn_clean  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_reset  = r_core_reset;
  assign bus.btn_clean   = r_btn_clean;
  assign bus.press_pulse = r_press_pulse;
  assign bus.press_count = r_press_count;

endmodule

// File: tb/tb_btn_reset_conditioner.sv
// Directed bench for btn_reset_conditioner with short debounce/reset windows;
// vectors give inputs for one edge and the outputs expected right after it.
module tb_btn_reset_conditioner;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   pulses;

  btn_reset_conditioner_if bus ();

  btn_reset_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .RESET_CYCLES   (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       raw;
    logic       cr;
    logic       bc;
    logic       pp;
    logic [7:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic raw, input logic cr,
                              input logic bc, input logic pp, input logic [7:0] pc);
    vec_t v;
    v.rst = rst; v.raw = raw; v.cr = cr; v.bc = bc; v.pp = pp; v.pc = pc;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic raw, input logic cr, input logic bc,
                      input logic pp, input logic [7:0] pc, input string tag, input int k);
    logic [10:0] act;
    logic [10:0] exp;
    @(negedge clk);
    reset       = rst;
    bus.btn_raw = raw;
    @(posedge clk);
    #1;
    act = {bus.core_reset, bus.btn_clean, bus.press_pulse, bus.press_count};
    exp = {cr, bc, pp, pc};
    if (bus.press_pulse === 1'b1) pulses++;
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got cr=%b bc=%b pp=%b pc=%0d, want cr=%b bc=%b pp=%b pc=%0d",
               tag, k, act[10], act[9], act[8], act[7:0], cr, bc, pp, pc);
    end
  endtask

  // One clean press: held 10 edges, released 10 edges, starting and ending in IDLE.
  task automatic do_press(input logic [7:0] pc0, input string tag);
    logic [7:0] pc1;
    pc1 = pc0 + 8'd1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, (k < 10), (k >= 6 && k < 16), (k >= 6 && k < 16), (k == 6),
           (k >= 6) ? pc1 : pc0, tag, k);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    pulses      = 0;
    reset       = 1'b1;
    bus.btn_raw = 1'b0;

    // Power-on: reset held, then a 3-cycle stretch.
    for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    // Glitch shorter than the debounce window.
    for (int k = 0; k < 10; k++) add(1'b0, (k < 3), 1'b0, 1'b0, 1'b0, 8'd0);
    // Clean press T0..T19, release from T20.
    for (int k = 0; k < 30; k++)
      add(1'b0, (k < 20), (k >= 6 && k < 26), (k >= 6 && k < 26), (k == 6),
          (k >= 6) ? 8'd1 : 8'd0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].raw, vecs[i].cr, vecs[i].bc, vecs[i].pp, vecs[i].pc, "table", i);

    // Release bounce: raw 0,0,1,1 then 0 while in WAIT_REL.
    for (int k = 0; k < 26; k++)
      step(1'b0, (k < 12) || (k == 14) || (k == 15), (k >= 6 && k < 22), (k >= 6 && k < 22),
           (k == 6), (k >= 6) ? 8'd2 : 8'd1, "bounce", k);

    // Held at power-up: POR goes to WAIT_REL, no press counted.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "held_rst", k);
    for (int k = 1; k <= 20; k++)
      step(1'b0, (k <= 10), (k < 17), (k >= 3 && k < 17), 1'b0, 8'd0, "held", k);

    // Four presses, then reset during RST_HOLD of the fifth (count 5).
    for (int p = 0; p < 4; p++) do_press(8'(p), "pre");
    for (int k = 0; k < 7; k++)
      step(1'b0, 1'b1, (k >= 6), (k >= 6), (k == 6), (k >= 6) ? 8'd5 : 8'd4, "fifth", k);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "midrst", 0);
    for (int k = 1; k <= 5; k++)
      step(1'b0, 1'b0, (k < 3), 1'b0, 1'b0, 8'd0, "post_por", k);

    // 256 presses wrap the counter back to zero.
    pulses = 0;
    for (int p = 0; p < 256; p++) do_press(8'(p), "wrap");
    total++;
    if (pulses != 256 || bus.press_count !== 8'd0) begin
      bad++;
      $display("FAIL wrap_total: got pulses=%0d pc=%0d, want pulses=256 pc=0",
               pulses, bus.press_count);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
